// File: rtl/mvm_pkg.sv
// Shared definitions for the tiled matrix-vector multiplier: FSM encoding,
// accumulator sizing and the ReLU decision.
package mvm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  // Wide enough that COLS full-width products plus a bias can never overflow.
  function automatic int unsigned acc_width(input int unsigned width, input int unsigned cols);
    return 2 * width + $clog2(cols) + 1;
  endfunction

  // Sign-aware ReLU: returns 1 when the value must be clamped to zero.
  function automatic logic relu_clamp(input logic sign_bit, input logic enable);
    return enable && sign_bit;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One signed multiply-accumulate lane; the first column seeds the sum with the bias.
module mac_lane #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = 19
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    first,
  input  logic                    last,
  input  logic signed [WIDTH-1:0] m,
  input  logic signed [WIDTH-1:0] v,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [ACC_W-1:0] sum,
  output logic                    sum_valid
);

  logic signed [ACC_W-1:0]   acc_q;
  logic signed [2*WIDTH-1:0] prod;

  always_comb begin
    prod = (2 * WIDTH)'(m) * (2 * WIDTH)'(v);
    sum  = (first ? ACC_W'(b) : acc_q) + ACC_W'(prod);
  end

  assign sum_valid = en & last;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sum;
    end
  end

endmodule

// File: rtl/mvm_tiled.sv
// Signed matrix-vector multiply plus bias with optional ReLU, LANES rows per pass,
// one column per cycle, valid/ready on both sides.
module mvm_tiled
  import mvm_pkg::*;
#(
  parameter int unsigned ROWS  = 6,
  parameter int unsigned COLS  = 3,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 2,
  localparam int unsigned ACC_W = acc_width(WIDTH, COLS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        relu,
  input  logic [ROWS*COLS*WIDTH-1:0]  matrix,
  input  logic [COLS*WIDTH-1:0]       vector,
  input  logic [ROWS*WIDTH-1:0]       bias,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ROWS*ACC_W-1:0]       result
);

  localparam int unsigned Passes = ROWS / LANES;
  localparam int unsigned ColW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned PassW  = (Passes > 1) ? $clog2(Passes) : 1;

  if (LANES == 0 || ROWS % LANES != 0) begin : g_bad_lanes
    $error("mvm_tiled: ROWS must be a non-zero multiple of LANES");
  end
  if (COLS < 1) begin : g_bad_cols
    $error("mvm_tiled: COLS must be at least 1");
  end

  state_e                     state_q, state_d;
  logic [ColW-1:0]            col_q, col_d;
  logic [PassW-1:0]           pass_q, pass_d;
  logic                       out_valid_q, out_valid_d;
  logic [ROWS*COLS*WIDTH-1:0] matrix_q;
  logic [COLS*WIDTH-1:0]      vector_q;
  logic [ROWS*WIDTH-1:0]      bias_q;
  logic                       relu_q;
  logic [ROWS*ACC_W-1:0]      result_q;
  logic                       accept, calc, last_col, last_pass;

  logic signed [ACC_W-1:0]    lane_sum [LANES];
  logic [ACC_W-1:0]           lane_out [LANES];
  logic [LANES-1:0]           lane_done;

  assign in_ready  = (state_q == StIdle);
  assign accept    = in_valid && in_ready;
  assign calc      = (state_q == StCalc);
  assign last_col  = (col_q == ColW'(COLS - 1));
  assign last_pass = (pass_q == PassW'(Passes - 1));
  assign out_valid = out_valid_q;
  assign result    = result_q;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    pass_d      = pass_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StCalc;
          col_d   = '0;
          pass_d  = '0;
        end
      end
      StCalc: begin
        if (last_col) begin
          col_d = '0;
          if (last_pass) begin
            pass_d  = '0;
            state_d = StDone;
          end else begin
            pass_d = pass_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      StDone: begin
        // out_valid trails DONE entry by one cycle, fixing the accept-to-valid latency.
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    int unsigned             row;
    logic signed [WIDTH-1:0] m_sel, v_sel, b_sel;

    always_comb begin
      row   = 32'(pass_q) * LANES + l;
      m_sel = matrix_q[(row * COLS + 32'(col_q)) * WIDTH +: WIDTH];
      v_sel = vector_q[32'(col_q) * WIDTH +: WIDTH];
      b_sel = bias_q[row * WIDTH +: WIDTH];
    end

    mac_lane #(
      .WIDTH(WIDTH),
      .ACC_W(ACC_W)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .en       (calc),
      .first    (col_q == '0),
      .last     (last_col),
      .m        (m_sel),
      .v        (v_sel),
      .b        (b_sel),
      .sum      (lane_sum[l]),
      .sum_valid(lane_done[l])
    );
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_out[l] = relu_clamp(lane_sum[l][ACC_W-1], relu_q) ? '0 : lane_sum[l];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      col_q       <= '0;
      pass_q      <= '0;
      out_valid_q <= 1'b0;
      matrix_q    <= '0;
      vector_q    <= '0;
      bias_q      <= '0;
      relu_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      pass_q      <= pass_d;
      out_valid_q <= out_valid_d;
      if (accept) begin
        matrix_q <= matrix;
        vector_q <= vector;
        bias_q   <= bias;
        relu_q   <= relu;
      end
      for (int l = 0; l < LANES; l++) begin
        if (lane_done[l]) begin
          result_q[(32'(pass_q) * LANES + l) * ACC_W +: ACC_W] <= lane_out[l];
        end
      end
    end
  end

endmodule

// File: tb/tb_mvm_tiled.sv
// Self-checking bench for mvm_tiled against an arithmetic reference model.
module tb_mvm_tiled;

  localparam int ROWS  = 6;
  localparam int COLS  = 3;
  localparam int WIDTH = 8;
  localparam int LANES = 2;
  localparam int ACC_W = 19;
  localparam int LAT   = (ROWS / LANES) * COLS + 1;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       in_valid;
  logic                       in_ready;
  logic                       relu;
  logic [ROWS*COLS*WIDTH-1:0] matrix;
  logic [COLS*WIDTH-1:0]      vector;
  logic [ROWS*WIDTH-1:0]      bias;
  logic                       out_valid;
  logic                       out_ready;
  logic [ROWS*ACC_W-1:0]      result;

  int total = 0;
  int bad   = 0;

  int m_a [ROWS][COLS];
  int v_a [COLS];
  int b_a [ROWS];
  bit relu_a;
  int exp_y [ROWS];

  always #5 clk = ~clk;

  mvm_tiled #(
    .ROWS (ROWS),
    .COLS (COLS),
    .WIDTH(WIDTH),
    .LANES(LANES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .relu     (relu),
    .matrix   (matrix),
    .vector   (vector),
    .bias     (bias),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  function automatic int rnd_elem();
    return int'($urandom_range(255)) - 128;
  endfunction

  function automatic void model();
    for (int r = 0; r < ROWS; r++) begin
      int s;
      s = b_a[r];
      for (int c = 0; c < COLS; c++) s += m_a[r][c] * v_a[c];
      if (relu_a && s < 0) s = 0;
      exp_y[r] = s;
    end
  endfunction

  function automatic logic [ROWS*ACC_W-1:0] pack_exp();
    logic [ROWS*ACC_W-1:0] p;
    for (int r = 0; r < ROWS; r++) begin
      logic [31:0] t;
      t = exp_y[r];
      p[r*ACC_W +: ACC_W] = t[ACC_W-1:0];
    end
    return p;
  endfunction

  task automatic drive_operands();
    for (int r = 0; r < ROWS; r++) begin
      logic [31:0] tb;
      tb = b_a[r];
      bias[r*WIDTH +: WIDTH] = tb[WIDTH-1:0];
      for (int c = 0; c < COLS; c++) begin
        logic [31:0] tm;
        tm = m_a[r][c];
        matrix[(r*COLS+c)*WIDTH +: WIDTH] = tm[WIDTH-1:0];
      end
    end
    for (int c = 0; c < COLS; c++) begin
      logic [31:0] tv;
      tv = v_a[c];
      vector[c*WIDTH +: WIDTH] = tv[WIDTH-1:0];
    end
    relu = relu_a;
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < ROWS * COLS; i++) matrix[i*WIDTH +: WIDTH] = 8'($urandom);
    for (int i = 0; i < COLS; i++) vector[i*WIDTH +: WIDTH] = 8'($urandom);
    for (int i = 0; i < ROWS; i++) bias[i*WIDTH +: WIDTH] = 8'($urandom);
    relu = ~relu_a;
  endtask

  // Called at posedge+#1 with in_ready high; returns edges from accept to out_valid.
  task automatic run_job(output int lat);
    drive_operands();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_inputs();
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic set_ones();
    for (int r = 0; r < ROWS; r++) begin
      b_a[r] = 0;
      for (int c = 0; c < COLS; c++) m_a[r][c] = 1;
    end
    for (int c = 0; c < COLS; c++) v_a[c] = c + 1;
    relu_a = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; relu = 1'b0;
    matrix = '0; vector = '0; bias = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (result !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
  endtask

  task automatic test_ones();
    int lat;
    logic [ACC_W-1:0] six;
    six = 19'd6;
    set_ones();
    out_ready = 1'b1;
    run_job(lat);
    model();
    total++; if (lat !== LAT) begin bad++; $display("FAIL ones_latency got=%0d want=%0d", lat, LAT); end
    total++; if (result !== pack_exp()) begin bad++; $display("FAIL ones_result got=%h want=%h", result, pack_exp()); end
    for (int r = 0; r < ROWS; r++) begin
      total++;
      if (result[r*ACC_W +: ACC_W] !== six) begin
        bad++; $display("FAIL ones_row%0d got=%h want=%h", r, result[r*ACC_W +: ACC_W], six);
      end
    end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL ones_handshake got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_extreme();
    int lat;
    logic [ROWS*ACC_W-1:0] want;
    for (int r = 0; r < ROWS; r++) begin
      b_a[r] = -128;
      want[r*ACC_W +: ACC_W] = 19'd49024;
      for (int c = 0; c < COLS; c++) m_a[r][c] = -128;
    end
    for (int c = 0; c < COLS; c++) v_a[c] = -128;
    relu_a = 1'b0;
    run_job(lat);
    total++; if (result !== want) begin bad++; $display("FAIL extreme_result got=%h want=%h", result, want); end
    total++; if (lat !== LAT) begin bad++; $display("FAIL extreme_latency got=%0d want=%0d", lat, LAT); end
    @(posedge clk); #1;
  endtask

  task automatic test_relu();
    int lat;
    logic [ACC_W-1:0] want0;
    for (int rl = 0; rl < 2; rl++) begin
      for (int r = 0; r < ROWS; r++) begin
        b_a[r] = rnd_elem();
        for (int c = 0; c < COLS; c++) m_a[r][c] = (r == 0) ? 1 : rnd_elem();
      end
      b_a[0] = 0;
      for (int c = 0; c < COLS; c++) v_a[c] = -5;
      relu_a = (rl == 1);
      want0 = relu_a ? 19'h0 : 19'h7FFF1;
      run_job(lat);
      model();
      total++; if (result[ACC_W-1:0] !== want0) begin
        bad++; $display("FAIL relu%0d_row0 got=%h want=%h", rl, result[ACC_W-1:0], want0);
      end
      total++; if (result !== pack_exp()) begin
        bad++; $display("FAIL relu%0d_result got=%h want=%h", rl, result, pack_exp());
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    int lat;
    for (int r = 0; r < ROWS; r++) begin
      b_a[r] = r - 3;
      for (int c = 0; c < COLS; c++) m_a[r][c] = 0;
    end
    for (int c = 0; c < COLS; c++) v_a[c] = rnd_elem();
    relu_a = 1'b0;
    out_ready = 1'b0;
    run_job(lat);
    model();
    total++; if (result[ACC_W-1:0] !== 19'h7FFFD) begin
      bad++; $display("FAIL stall_row0 got=%h want=7fffd", result[ACC_W-1:0]);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      scramble_inputs();
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== pack_exp()) begin
        bad++; $display("FAIL stall_hold%0d got valid=%b ready=%b res=%h want valid=1 ready=0 res=%h",
                        i, out_valid, in_ready, result, pack_exp());
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== pack_exp()) begin
      bad++; $display("FAIL stall_release got valid=%b ready=%b res=%h want valid=0 ready=1 res=%h",
                      out_valid, in_ready, result, pack_exp());
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    set_ones();
    drive_operands();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
      bad++; $display("FAIL midreset got valid=%b ready=%b res=%h want valid=0 ready=1 res=0",
                      out_valid, in_ready, result);
    end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || result !== '0) begin
      bad++; $display("FAIL midreset_idle got valid=%b res=%h want valid=0 res=0", out_valid, result);
    end
    run_job(lat);
    model();
    total++; if (lat !== LAT) begin bad++; $display("FAIL midreset_latency got=%0d want=%0d", lat, LAT); end
    total++; if (result !== pack_exp()) begin
      bad++; $display("FAIL midreset_result got=%h want=%h", result, pack_exp());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      for (int r = 0; r < ROWS; r++) begin
        b_a[r] = rnd_elem();
        for (int c = 0; c < COLS; c++) m_a[r][c] = rnd_elem();
      end
      for (int c = 0; c < COLS; c++) v_a[c] = rnd_elem();
      relu_a = 1'($urandom);
      run_job(lat);
      model();
      total++; if (lat !== LAT) begin bad++; $display("FAIL b2b%0d_latency got=%0d want=%0d", j, lat, LAT); end
      total++; if (result !== pack_exp()) begin
        bad++; $display("FAIL b2b%0d_result got=%h want=%h", j, result, pack_exp());
      end
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++; $display("FAIL b2b%0d_gap got ready=%b valid=%b want ready=1 valid=0", j, in_ready, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_extreme();
    test_relu();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
